// File: rtl/sent_tx_fifo_if.sv
// Handshake and status bundle between the APB register slave / frame engine
// and the SENT transmit FIFO.
interface sent_tx_fifo_if #(
    parameter int DATAWIDTH  = 12,
    parameter int ADDR_WIDTH = 3
);
    logic                  write_enable_tx;
    logic [DATAWIDTH-1:0]  data_in;
    logic                  read_enable;
    logic                  flush;
    logic                  err_clear;
    logic [DATAWIDTH-1:0]  data_out;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   fifo_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_enable_tx, data_in, read_enable, flush, err_clear,
        input  data_out, fifo_empty, fifo_full, almost_full, fifo_count,
               overflow, underflow
    );

    modport slave (
        input  write_enable_tx, data_in, read_enable, flush, err_clear,
        output data_out, fifo_empty, fifo_full, almost_full, fifo_count,
               overflow, underflow
    );
endinterface

// File: rtl/sent_tx_fifo.sv
// SENT transmit data FIFO: first-word-fall-through register array with
// registered status flags and sticky overflow/underflow error bits.
module sent_tx_fifo #(
    parameter int DATAWIDTH         = 12,
    parameter int DEPTH             = 8,
    parameter int ADDR_WIDTH        = 3,
    parameter int ALMOST_FULL_LEVEL = 6
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    sent_tx_fifo_if.slave   bus
);
    localparam logic [ADDR_WIDTH:0] L_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_AF   = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);

    logic [DATAWIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_ovf_evt;
    logic                  w_unf_evt;
    logic [ADDR_WIDTH:0]   w_count_next;

    // A push into a full FIFO is legal only when a real pop frees a slot
    // on the same edge; flush overrides both directions.
    always_comb begin
        w_pop_ok     = bus.read_enable & ~r_empty & ~bus.flush;
        w_push_ok    = bus.write_enable_tx & ~bus.flush & (~r_full | w_pop_ok);
        w_ovf_evt    = bus.write_enable_tx & ~bus.flush & r_full & ~w_pop_ok;
        w_unf_evt    = bus.read_enable & ~bus.flush & r_empty;
        w_count_next = r_count;
        if (bus.flush) begin
            w_count_next = '0;
        end else if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count       <= w_count_next;
            r_empty       <= (w_count_next == '0);
            r_full        <= (w_count_next == L_FULL);
            r_almost_full <= (w_count_next >= L_AF);
            // A fresh error on the clearing edge takes precedence.
            r_overflow    <= w_ovf_evt | (r_overflow  & ~bus.err_clear);
            r_underflow   <= w_unf_evt | (r_underflow & ~bus.err_clear);
        end
    end

    assign bus.data_out    = r_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.fifo_empty  = r_empty;
    assign bus.fifo_full   = r_full;
    assign bus.almost_full = r_almost_full;
    assign bus.fifo_count  = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_sent_tx_fifo.sv
// Scoreboard bench for sent_tx_fifo: a queue-based reference model predicts
// the state after every edge; a monitor compares it on the following falling edge.
`timescale 1ns/1ps
module tb_sent_tx_fifo;
    logic PCLK;
    logic PRESETn;

    sent_tx_fifo_if #(.DATAWIDTH(12), .ADDR_WIDTH(3)) bus ();

    sent_tx_fifo #(
        .DATAWIDTH(12), .DEPTH(8), .ADDR_WIDTH(3), .ALMOST_FULL_LEVEL(6)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .bus(bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int count;
        bit empty;
        bit full;
        bit af;
        bit ovf;
        bit unf;
        int head;
    } exp_t;

    exp_t exp_q[$];
    int   ref_q[$];
    bit   m_ovf;
    bit   m_unf;
    int   checks;
    int   errors;
    int   txn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is just an ordered list of at most 8 words.
    task automatic model_step(input bit we, input int d, input bit re, input bit fl, input bit ec);
        bit pop_ok;
        bit push_ok;
        bit ovf_evt;
        bit unf_evt;
        exp_t e;
        ovf_evt = 0;
        unf_evt = 0;
        if (fl) begin
            ref_q.delete();
        end else begin
            pop_ok  = re && (ref_q.size() > 0);
            push_ok = we && ((ref_q.size() < 8) || pop_ok);
            ovf_evt = we && !push_ok;
            unf_evt = re && (ref_q.size() == 0);
            if (pop_ok)  void'(ref_q.pop_front());
            if (push_ok) ref_q.push_back(d);
        end
        m_ovf = ovf_evt || (m_ovf && !ec);
        m_unf = unf_evt || (m_unf && !ec);
        e.count = ref_q.size();
        e.empty = (ref_q.size() == 0);
        e.full  = (ref_q.size() == 8);
        e.af    = (ref_q.size() >= 6);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.head  = (ref_q.size() > 0) ? ref_q[0] : -1;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit we, input int d, input bit re, input bit fl, input bit ec);
        logic [11:0] d12;
        d12 = d[11:0];
        @(negedge PCLK);
        bus.write_enable_tx = we;
        bus.data_in         = d12;
        bus.read_enable     = re;
        bus.flush           = fl;
        bus.err_clear       = ec;
        @(posedge PCLK);
        #1;
        model_step(we, int'(d12), re, fl, ec);
    endtask

    task automatic idle_inputs();
        bus.write_enable_tx = 1'b0;
        bus.data_in         = '0;
        bus.read_enable     = 1'b0;
        bus.flush           = 1'b0;
        bus.err_clear       = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
        chk({tag, "_empty"}, 32'(bus.fifo_empty), 32'd1);
        chk({tag, "_full"},  32'(bus.fifo_full),  32'd0);
        chk({tag, "_af"},    32'(bus.almost_full), 32'd0);
        chk({tag, "_ovf"},   32'(bus.overflow),   32'd0);
        chk({tag, "_unf"},   32'(bus.underflow),  32'd0);
        chk({tag, "_dout"},  32'(bus.data_out),   32'd0);
    endtask

    // Monitor: one expected record per edge, compared away from the active edge.
    always @(negedge PCLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            txn++;
            chk("count", 32'(bus.fifo_count), 32'(e.count));
            chk("empty", 32'(bus.fifo_empty), 32'(e.empty));
            chk("full",  32'(bus.fifo_full),  32'(e.full));
            chk("almost_full", 32'(bus.almost_full), 32'(e.af));
            chk("overflow",  32'(bus.overflow),  32'(e.ovf));
            chk("underflow", 32'(bus.underflow), 32'(e.unf));
            if (!e.empty) chk("data_out", 32'(bus.data_out), 32'(e.head));
            $display("txn %0d: count=%0d empty=%0b full=%0b af=%0b ovf=%0b unf=%0b dout=0x%03h",
                     txn, bus.fifo_count, bus.fifo_empty, bus.fifo_full, bus.almost_full,
                     bus.overflow, bus.underflow, bus.data_out);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        txn    = 0;
        m_ovf  = 0;
        m_unf  = 0;
        idle_inputs();
        PRESETn = 1'b0;
        #7;
        check_reset_state("reset");
        #6 PRESETn = 1'b1;

        // Single word round trip.
        cycle(1, 'hA5C, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 9; i++) cycle(1, i, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);

        // Full with simultaneous push and pop, then drain across the wrap.
        for (int i = 1; i <= 8; i++) cycle(1, i, 0, 0, 0);
        cycle(1, 'h0FF, 1, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0);

        // Pop on empty with simultaneous push.
        cycle(1, 'h3C3, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0);

        // Flush keeps sticky errors and drops the concurrent push.
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 'h100 + i, 0, 0, 0);
        cycle(1, 'h777, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 3; i++) cycle(1, 'h200 + i, 0, 0, 0);
        @(negedge PCLK);
        idle_inputs();
        #1;
        PRESETn = 1'b0;
        #1;
        check_reset_state("async_reset");
        ref_q.delete();
        m_ovf = 0;
        m_unf = 0;
        @(negedge PCLK);
        #1 PRESETn = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            bit we;
            bit re;
            bit fl;
            bit ec;
            we = ($urandom_range(0, 99) < 55);
            re = ($urandom_range(0, 99) < 50);
            fl = ($urandom_range(0, 39) == 0);
            ec = ($urandom_range(0, 19) == 0);
            cycle(we, int'($urandom_range(0, 4095)), re, fl, ec);
        end

        @(negedge PCLK);
        idle_inputs();
        @(negedge PCLK);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sent_tx_fifo.md
Name: sent_tx_fifo

Overview:
- Transmit data FIFO directly downstream of the APB register slave.
- Captures 12-bit transmit words pushed by write_enable_tx/reg_transmit.
- Buffers them for the SENT transmit frame engine, which pops one word per frame.
- Reports full/empty/level/error status back into the status register (fifo_full drives reg_status[7]).

Parameters:
DATAWIDTH, 12, width of one stored word (matches reg_transmit)
DEPTH, 8, number of entries; power of two
ADDR_WIDTH, 3, log2(DEPTH); pointer width
ALMOST_FULL_LEVEL, 6, fifo_count threshold for almost_full

Ports:
PCLK  input  1  system clock, all logic on rising edge
PRESETn  input  1  asynchronous active-low reset
write_enable_tx  input  1  push request from APB slave, one entry per high cycle
data_in  input  DATAWIDTH  push data (reg_transmit)
read_enable  input  1  pop request from transmit frame engine
flush  input  1  synchronous flush (reg_command control bit)
err_clear  input  1  synchronous clear of sticky error flags
data_out  output  DATAWIDTH  head-of-queue word, first-word-fall-through
fifo_empty  output  1  no entries stored
fifo_full  output  1  DEPTH entries stored
almost_full  output  1  fifo_count >= ALMOST_FULL_LEVEL
fifo_count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
Reset (PRESETn low, asynchronous):
- wr_ptr=0, rd_ptr=0, fifo_count=0, fifo_empty=1, fifo_full=0, almost_full=0, overflow=0, underflow=0, data_out=0.
- Storage array contents are not reset.
- Reset asserted mid-operation discards all entries immediately.

Storage:
- DEPTH x DATAWIDTH register array.
- Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally.
- fifo_count is a separate registered counter.

Push:
- On a PCLK edge with write_enable_tx=1 and (fifo_full=0, or read_enable=1 with fifo_empty=0): mem[wr_ptr]<=data_in, wr_ptr+1.
- Push while full without a simultaneous valid pop: data dropped, pointers unchanged, overflow<=1.

Pop:
- On a PCLK edge with read_enable=1 and fifo_empty=0: rd_ptr+1.
- Pop while empty: no pointer change, underflow<=1. A simultaneous push still succeeds.

Count update per edge:
- +1 on push only.
- -1 on pop only.
- Unchanged when both occur or neither occurs.

Flags (all registered, derived from next count, valid the cycle after the causing edge):
- fifo_empty = (count==0)
- fifo_full = (count==DEPTH)
- almost_full = (count>=ALMOST_FULL_LEVEL)

data_out:
- Equals mem[rd_ptr] combinationally; FWFT.
- Valid whenever fifo_empty=0; value undefined (don't-care) when empty.
- A word pushed into an empty FIFO appears on data_out the cycle after the push edge.

Latency: push edge -> fifo_empty deasserted next cycle. No bypass.

flush:
- Highest priority after reset.
- Pointers and count go to 0, flags to the reset state.
- Push/pop in the same cycle are ignored; sticky errors are not changed.

err_clear:
- Clears overflow/underflow.
- If a new error occurs in the same cycle, the set wins.

Upstream handshake:
- APB slave gates writes on fifo_full (reg_status[7]).
- Overflow can still occur when a push arrives in the same cycle the FIFO becomes full; the FIFO must flag it, never corrupt stored data.

Test Plan:
- Reset, then push 0xA5C -> next cycle fifo_empty=0, fifo_count=1, data_out=0xA5C; pop -> fifo_empty=1, count=0.
- Push 0x001..0x008 on consecutive cycles -> almost_full=1 once count=6, fifo_full=1 at count=8; 9th push 0x009 -> overflow=1, count stays 8; pop x8 returns 0x001..0x008 in order.
- Fill to 8, then simultaneous push 0x0FF + pop -> count stays 8, fifo_full stays 1, head advances to 0x002; after draining, last word is 0x0FF (pointer wrap verified).
- Empty FIFO, read_enable=1 with write_enable_tx=1 data 0x3C3 -> underflow=1, count=1, data_out=0x3C3 next cycle; err_clear -> underflow=0.
- Push 5 words, assert flush together with push 0x777 -> count=0, fifo_empty=1, 0x777 not stored; overflow/underflow unchanged.
- Push 3 words, drop PRESETn asynchronously between clock edges -> outputs return to reset values immediately, before the next PCLK edge.
